// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer: assembles sof-framed bit streams into WIDTH-bit
// words, holds one finished word on a valid/ready port, and flags overflow/framing errors.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             err_overflow,
  output logic             err_frame,
  input  logic             clr_err
);

  // Handshake: a word transfers on any edge where pout_valid=1 and pout_ready=1;
  // pout/pout_valid are registers and never depend combinationally on pout_ready.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_pout;
  logic             r_pout_valid;
  logic             r_err_ovf;
  logic             r_err_frm;

  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_append;
  logic             w_frame;
  logic             w_complete;
  logic             w_free;

  // First bit of a word seeds the end of the register that shifts towards its final slot.
  always_comb begin
    w_first  = '0;
    w_append = '0;
    if (MSB_FIRST) begin
      w_first  = {{(WIDTH-1){1'b0}}, sin};
      w_append = {r_shift[WIDTH-2:0], sin};
    end else begin
      w_first  = {sin, {(WIDTH-1){1'b0}}};
      w_append = {sin, r_shift[WIDTH-1:1]};
    end
  end

  assign w_frame    = (r_state == SHIFT) && sin_valid && sof;
  assign w_complete = (r_state == SHIFT) && sin_valid && !sof && (r_cnt == LAST_IDX);
  assign w_free     = !r_pout_valid || pout_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_frm    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sin_valid && sof) begin
            r_shift <= w_first;
            r_cnt   <= CW'(1);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sin_valid) begin
            if (sof) begin
              r_shift <= w_first;
              r_cnt   <= CW'(1);
            end else if (r_cnt == LAST_IDX) begin
              r_shift <= w_append;
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_shift <= w_append;
              r_cnt   <= r_cnt + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_complete) begin
        if (w_free) begin
          r_pout       <= w_append;
          r_pout_valid <= 1'b1;
        end
      end else if (r_pout_valid && pout_ready) begin
        r_pout_valid <= 1'b0;
      end

      // Set events win over a simultaneous clear.
      if (w_complete && !w_free) r_err_ovf <= 1'b1;
      else if (clr_err)          r_err_ovf <= 1'b0;

      if (w_frame)      r_err_frm <= 1'b1;
      else if (clr_err) r_err_frm <= 1'b0;
    end
  end

  assign pout         = r_pout;
  assign pout_valid   = r_pout_valid;
  assign busy         = (r_state == SHIFT);
  assign err_overflow = r_err_ovf;
  assign err_frame    = r_err_frm;

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer: an MSB-first and an LSB-first instance share one
// serial stream and are checked against hand-computed words.
module tb_sipo_deframer;

  logic       clock;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       sof;
  logic       pout_ready;
  logic       clr_err;

  logic [3:0] pout_m;
  logic       valid_m;
  logic       busy_m;
  logic       ovf_m;
  logic       frm_m;

  logic [3:0] pout_l;
  logic       valid_l;
  logic       busy_l;
  logic       ovf_l;
  logic       frm_l;

  int n_vec;
  int n_err;

  sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .pout(pout_m), .pout_valid(valid_m), .pout_ready(pout_ready), .busy(busy_m),
    .err_overflow(ovf_m), .err_frame(frm_m), .clr_err(clr_err)
  );

  sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .pout(pout_l), .pout_valid(valid_l), .pout_ready(pout_ready), .busy(busy_l),
    .err_overflow(ovf_l), .err_frame(frm_l), .clr_err(clr_err)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs are read there too.
  task automatic send_bit(input logic b, input logic s);
    sin       = b;
    sof       = s;
    sin_valid = 1'b1;
    @(posedge clock);
    #1;
    sin_valid = 1'b0;
    sof       = 1'b0;
    sin       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_word(input logic [3:0] w);
    send_bit(w[3], 1'b1);
    send_bit(w[2], 1'b0);
    send_bit(w[1], 1'b0);
    send_bit(w[0], 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_vec++; if (pout_m !== 4'h0)   begin $display("FAIL reset_pout got %h exp 0", pout_m); n_err++; end
    n_vec++; if (valid_m !== 1'b0)  begin $display("FAIL reset_valid got %b exp 0", valid_m); n_err++; end
    n_vec++; if ({busy_m, ovf_m, frm_m, busy_l} !== 4'b0) begin
      $display("FAIL reset_flags got %b exp 0000", {busy_m, ovf_m, frm_m, busy_l}); n_err++; end
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic;
    pout_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    n_vec++; if (busy_m !== 1'b1) begin $display("FAIL basic_busy got %b exp 1", busy_m); n_err++; end
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    n_vec++; if (valid_m !== 1'b0) begin $display("FAIL basic_early_valid got %b exp 0", valid_m); n_err++; end
    send_bit(1'b0, 1'b0);
    n_vec++; if (valid_m !== 1'b1) begin $display("FAIL basic_valid got %b exp 1", valid_m); n_err++; end
    n_vec++; if (pout_m !== 4'b1010) begin $display("FAIL basic_pout_msb got %b exp 1010", pout_m); n_err++; end
    n_vec++; if (pout_l !== 4'b0101) begin $display("FAIL basic_pout_lsb got %b exp 0101", pout_l); n_err++; end
    n_vec++; if (busy_m !== 1'b0) begin $display("FAIL basic_busy_done got %b exp 0", busy_m); n_err++; end
    idle(1);
    n_vec++; if (valid_m !== 1'b0) begin $display("FAIL basic_valid_drop got %b exp 0", valid_m); n_err++; end
    n_vec++; if (pout_m !== 4'b1010) begin $display("FAIL basic_pout_keep got %b exp 1010", pout_m); n_err++; end
  endtask

  task automatic test_gaps;
    logic [3:0] bits;
    bits = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i], (i == 3));
      if (i != 0) begin
        idle(3);
        n_vec++; if (busy_l !== 1'b1) begin $display("FAIL gap_busy got %b exp 1", busy_l); n_err++; end
        n_vec++; if (valid_l !== 1'b0) begin $display("FAIL gap_valid got %b exp 0", valid_l); n_err++; end
      end
    end
    n_vec++; if (valid_l !== 1'b1) begin $display("FAIL gap_done_valid got %b exp 1", valid_l); n_err++; end
    n_vec++; if (pout_l !== 4'b0101) begin $display("FAIL gap_pout_lsb got %b exp 0101", pout_l); n_err++; end
    idle(1);
  endtask

  task automatic test_overflow;
    pout_ready = 1'b0;
    send_word(4'b1100);
    n_vec++; if (pout_m !== 4'b1100 || valid_m !== 1'b1) begin
      $display("FAIL ovf_first got %b/%b exp 1100/1", pout_m, valid_m); n_err++; end
    n_vec++; if (pout_l !== 4'b0011) begin $display("FAIL ovf_first_lsb got %b exp 0011", pout_l); n_err++; end
    send_word(4'b0011);
    n_vec++; if (pout_m !== 4'b1100 || valid_m !== 1'b1) begin
      $display("FAIL ovf_hold got %b/%b exp 1100/1", pout_m, valid_m); n_err++; end
    n_vec++; if (ovf_m !== 1'b1 || ovf_l !== 1'b1) begin
      $display("FAIL ovf_flag got %b%b exp 11", ovf_m, ovf_l); n_err++; end
    pout_ready = 1'b1;
    idle(1);
    n_vec++; if (valid_m !== 1'b0) begin $display("FAIL ovf_handshake got %b exp 0", valid_m); n_err++; end
    send_word(4'b0110);
    n_vec++; if (pout_m !== 4'b0110 || valid_m !== 1'b1) begin
      $display("FAIL ovf_next got %b/%b exp 0110/1", pout_m, valid_m); n_err++; end
    n_vec++; if (ovf_m !== 1'b1) begin $display("FAIL ovf_sticky got %b exp 1", ovf_m); n_err++; end
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    n_vec++; if (ovf_m !== 1'b0 || valid_m !== 1'b0) begin
      $display("FAIL ovf_clear got ovf=%b valid=%b exp 0/0", ovf_m, valid_m); n_err++; end
  endtask

  task automatic test_frame;
    pout_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    n_vec++; if (frm_m !== 1'b1 || busy_m !== 1'b1) begin
      $display("FAIL frame_flag got frm=%b busy=%b exp 1/1", frm_m, busy_m); n_err++; end
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    n_vec++; if (valid_m !== 1'b0) begin $display("FAIL frame_no_partial got %b exp 0", valid_m); n_err++; end
    send_bit(1'b1, 1'b0);
    n_vec++; if (pout_m !== 4'b1111 || valid_m !== 1'b1) begin
      $display("FAIL frame_word got %b/%b exp 1111/1", pout_m, valid_m); n_err++; end
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    n_vec++; if (frm_m !== 1'b0) begin $display("FAIL frame_clear got %b exp 0", frm_m); n_err++; end
    // sof in the last-bit slot restarts the word; a simultaneous clear loses to the set.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    clr_err = 1'b1;
    send_bit(1'b0, 1'b1);
    clr_err = 1'b0;
    n_vec++; if (frm_m !== 1'b1 || busy_m !== 1'b1 || valid_m !== 1'b0) begin
      $display("FAIL frame_last_slot got frm=%b busy=%b valid=%b exp 1/1/0", frm_m, busy_m, valid_m); n_err++; end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    n_vec++; if (pout_m !== 4'b0101 || valid_m !== 1'b1) begin
      $display("FAIL frame_restart got %b/%b exp 0101/1", pout_m, valid_m); n_err++; end
    n_vec++; if (pout_l !== 4'b1010) begin $display("FAIL frame_restart_lsb got %b exp 1010", pout_l); n_err++; end
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
  endtask

  task automatic test_no_sof;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, 1'b0);
      n_vec++; if (busy_m !== 1'b0 || valid_m !== 1'b0) begin
        $display("FAIL nosof_ignored got busy=%b valid=%b exp 0/0", busy_m, valid_m); n_err++; end
    end
  endtask

  task automatic test_async_reset;
    pout_ready = 1'b0;
    send_word(4'b1001);
    n_vec++; if (pout_m !== 4'b1001 || valid_m !== 1'b1) begin
      $display("FAIL arst_pre got %b/%b exp 1001/1", pout_m, valid_m); n_err++; end
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({pout_m, valid_m, busy_m, ovf_m, frm_m} !== 8'h00) begin
      $display("FAIL arst_outputs got %b exp 00000000", {pout_m, valid_m, busy_m, ovf_m, frm_m}); n_err++; end
    n_vec++; if ({pout_l, valid_l, busy_l} !== 6'h00) begin
      $display("FAIL arst_outputs_lsb got %b exp 000000", {pout_l, valid_l, busy_l}); n_err++; end
    @(negedge clock);
    rst_n = 1'b1;
    pout_ready = 1'b1;
    @(posedge clock);
    #1;
    send_word(4'b0111);
    n_vec++; if (pout_m !== 4'b0111 || valid_m !== 1'b1) begin
      $display("FAIL arst_after got %b/%b exp 0111/1", pout_m, valid_m); n_err++; end
    n_vec++; if (pout_l !== 4'b1110) begin $display("FAIL arst_after_lsb got %b exp 1110", pout_l); n_err++; end
    idle(1);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    sof        = 1'b0;
    pout_ready = 1'b1;
    clr_err    = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_frame();
    test_no_sof();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Serial-in/parallel-out receiver that sits directly downstream of the parallel-to-serial shifter.
- Collects framed serial bits into WIDTH-bit words and presents each word on a valid/ready output port.
- Holds one completed word while the next word is being shifted in.
- Flags overflow and framing errors with sticky status bits.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in pout[WIDTH-1]; 0 = first bit lands in pout[0].

Ports:
clock  input  1  rising-edge clock for all state.
rst_n  input  1  asynchronous, active-low reset.
sin  input  1  serial data bit; sampled only when sin_valid=1.
sin_valid  input  1  qualifies sin on this clock edge.
sof  input  1  start-of-frame; meaningful only when sin_valid=1; marks the first bit of a word.
pout  output  WIDTH  assembled word; stable while pout_valid=1.
pout_valid  output  1  output holding register contains a word.
pout_ready  input  1  consumer accepts the word when pout_valid=1 and pout_ready=1.
busy  output  1  1 while a word is partially received (state SHIFT).
err_overflow  output  1  sticky: a completed word was dropped because the holding register was full.
err_frame  output  1  sticky: sof arrived while a word was partially received.
clr_err  input  1  synchronous clear of both sticky error bits.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit counter=0, shift register=0, pout=0, pout_valid=0, busy=0, err_overflow=0, err_frame=0.
- States are IDLE and SHIFT. busy is 1 exactly when state=SHIFT.
- IDLE:
  - sin_valid=1 with sof=0: bit ignored, no state change.
  - sin_valid=1 with sof=1: sin becomes bit 0 of the word, counter=1, go to SHIFT.
- SHIFT with sin_valid=0: hold all state. Gaps between bits are unlimited.
- SHIFT with sin_valid=1, sof=0: append sin, counter+1.
  - When the appended bit is bit WIDTH-1, the word is complete. Counter returns to 0 and state goes to IDLE.
- SHIFT with sin_valid=1, sof=1 (at any counter value, including the last-bit position):
  - Partial word discarded; err_frame set.
  - sin becomes bit 0 of a new word, counter=1, remain in SHIFT.
- Bit ordering:
  - MSB_FIRST=1: shift register shifts left with the new bit entering the LSB, so the first bit ends up in pout[WIDTH-1].
  - MSB_FIRST=0: shift register shifts right with the new bit entering the MSB, so the first bit ends up in pout[0].
- Completion and transfer:
  - Holding register free means pout_valid=0, or pout_valid=1 and pout_ready=1 on the same edge.
  - If free on the completing edge: pout loads the full word and pout_valid=1 from the next cycle. Latency is 1 clock from the last bit's sampling edge.
  - If not free: the word is dropped, pout and pout_valid are unchanged, err_overflow is set.
  - Handshake on an edge with no completion: pout_valid goes to 0 and pout keeps its last value.
- Output stability: once pout_valid=1, pout and pout_valid stay unchanged until the handshake. pout_valid never depends combinationally on pout_ready.
- Back-to-back words: the sof for the next word may arrive on the clock immediately after the last bit. No dead cycles are required.
- Error bits:
  - A set event has priority over clr_err on the same edge.
  - Otherwise clr_err=1 clears both bits on the next edge.
- Reset mid-word or with pout_valid=1: all state is lost and the word in progress is not delivered.

Test Plan:
- WIDTH=4, MSB_FIRST=1, pout_ready=1: send bits 1,0,1,0 with sof on the first bit, sin_valid held high -> pout=4'b1010 and pout_valid=1 exactly one cycle after the 4th bit; pout_valid=0 the following cycle.
- Same stream with MSB_FIRST=0 -> pout=4'b0101. Insert 3-cycle sin_valid=0 gaps between bits -> same result, busy=1 throughout the gaps.
- pout_ready=0: send 1100 then 0011 back-to-back -> pout stays 4'b1100 with pout_valid=1, err_overflow=1. Raise pout_ready -> handshake; a following 0110 word is delivered normally.
- Send 1,0 then sof with bits 1,1,1,1 -> err_frame=1 and only 4'b1111 is delivered. Pulse clr_err -> err_frame=0 next cycle.
- Bits arriving without sof while IDLE (1,1,1) -> ignored, busy=0, no pout_valid.
- Assert rst_n=0 asynchronously after 2 bits of a word, with pout_valid=1 holding 4'b1001 -> all outputs zero immediately. After release, the next sof-framed word 0111 is received correctly.
